// File: rtl/decode_pkg.sv
// decode_pkg: shared types and opcode constants for the decode stage.
// Format enum, major-opcode codes and the registered payload struct.
package decode_pkg;

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_R,
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J
  } fmt_t;

  localparam logic [4:0] OPC_LUI     = 5'b01101;
  localparam logic [4:0] OPC_AUIPC   = 5'b00101;
  localparam logic [4:0] OPC_JAL     = 5'b11011;
  localparam logic [4:0] OPC_JALR    = 5'b11001;
  localparam logic [4:0] OPC_BRANCH  = 5'b11000;
  localparam logic [4:0] OPC_LOAD    = 5'b00000;
  localparam logic [4:0] OPC_STORE   = 5'b01000;
  localparam logic [4:0] OPC_OPIMM   = 5'b00100;
  localparam logic [4:0] OPC_OP      = 5'b01100;
  localparam logic [4:0] OPC_OPIMM32 = 5'b00110;
  localparam logic [4:0] OPC_OP32    = 5'b01110;
  localparam logic [4:0] OPC_MISCMEM = 5'b00011;
  localparam logic [4:0] OPC_SYSTEM  = 5'b11100;

  typedef struct packed {
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    fmt_t       fmt;
    logic       illegal;
  } decoded_t;

endpackage

// File: rtl/decode_if.sv
// decode_if: fetch-side and execute-side handshakes of the decode stage.
// slave is the stage itself, master is whoever drives and consumes it.
interface decode_if
  import decode_pkg::*;
#(
  parameter int XLEN = 32
) ();

  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_insn;
  logic [XLEN-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic [4:0]      rd;
  logic [XLEN-1:0] imm;
  fmt_t            fmt;
  logic            illegal;

  modport slave (
    input  flush, in_valid, in_insn, in_pc, out_ready,
    output in_ready, out_valid, out_pc, opcode, funct3,
    output funct7, rs1, rs2, rd, imm, fmt, illegal
  );

  modport master (
    output flush, in_valid, in_insn, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, opcode, funct3,
    input  funct7, rs1, rs2, rd, imm, fmt, illegal
  );

endinterface

// File: rtl/decode_fields.sv
// decode_fields: combinational split of one instruction into fields,
// format class, sign-extended immediate and the illegal flag.
module decode_fields
  import decode_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     insn,
  output decoded_t        dec,
  output logic [XLEN-1:0] imm
);

  localparam bit RV64 = (XLEN == 64);

  logic [4:0] opc;
  fmt_t       fmt_raw;
  logic       ill;

  assign opc = insn[6:2];
  assign ill = (insn[1:0] != 2'b11) || (fmt_raw == FMT_NONE);

  // classify by major opcode; *W opcodes only exist on RV64
  always_comb begin
    fmt_raw = FMT_NONE;
    unique case (1'b1)
      (opc == OPC_LUI) || (opc == OPC_AUIPC): fmt_raw = FMT_U;
      (opc == OPC_JAL):    fmt_raw = FMT_J;
      (opc == OPC_BRANCH): fmt_raw = FMT_B;
      (opc == OPC_JALR) || (opc == OPC_OPIMM) ||
      (opc == OPC_LOAD) || (opc == OPC_MISCMEM) ||
      (opc == OPC_SYSTEM) ||
      (RV64 && (opc == OPC_OPIMM32)): fmt_raw = FMT_I;
      (opc == OPC_STORE):  fmt_raw = FMT_S;
      (opc == OPC_OP) ||
      (RV64 && (opc == OPC_OP32)): fmt_raw = FMT_R;
      default: fmt_raw = FMT_NONE;
    endcase
  end

  // raw fields pass through; illegal forces fmt to NONE
  always_comb begin
    dec.opcode  = insn[6:0];
    dec.funct3  = insn[14:12];
    dec.funct7  = insn[31:25];
    dec.rs1     = insn[19:15];
    dec.rs2     = insn[24:20];
    dec.rd      = insn[11:7];
    dec.illegal = ill;
    dec.fmt     = ill ? FMT_NONE : fmt_raw;
  end

  // immediate assembly, sign-extended from insn[31]
  always_comb begin
    imm = '0;
    unique case (dec.fmt)
      FMT_I: imm = XLEN'($signed(insn[31:20]));
      FMT_S: imm = XLEN'($signed({insn[31:25], insn[11:7]}));
      FMT_B: imm = XLEN'($signed({insn[31], insn[7],
                   insn[30:25], insn[11:8], 1'b0}));
      FMT_U: imm = XLEN'($signed({insn[31:12], 12'b0}));
      FMT_J: imm = XLEN'($signed({insn[31], insn[19:12],
                   insn[20], insn[30:21], 1'b0}));
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// decode_stage: registered decode with a one-entry skid buffer
// so the fetch side keeps full throughput under backpressure.
module decode_stage
  import decode_pkg::*;
#(
  parameter int XLEN = 32
) (
  input logic     clk,
  input logic     reset,
  decode_if.slave bus
);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    decoded_t        dec;
  } payload_t;

  decoded_t        in_dec;
  logic [XLEN-1:0] in_imm;
  payload_t        in_pl;
  payload_t        out_q, out_d;
  payload_t        skid_q, skid_d;
  logic            out_vld_q, out_vld_d;
  logic            skid_vld_q, skid_vld_d;
  logic            in_fire, out_fire;

  decode_fields #(.XLEN(XLEN)) u_fields (
    .insn (bus.in_insn),
    .dec  (in_dec),
    .imm  (in_imm)
  );

  assign in_pl    = '{pc: bus.in_pc, imm: in_imm, dec: in_dec};
  assign in_fire  = bus.in_valid && bus.in_ready;
  assign out_fire = out_vld_q && bus.out_ready;

  assign bus.in_ready  = !skid_vld_q && !reset;
  assign bus.out_valid = out_vld_q;
  assign bus.out_pc    = out_q.pc;
  assign bus.imm       = out_q.imm;
  assign bus.opcode    = out_q.dec.opcode;
  assign bus.funct3    = out_q.dec.funct3;
  assign bus.funct7    = out_q.dec.funct7;
  assign bus.rs1       = out_q.dec.rs1;
  assign bus.rs2       = out_q.dec.rs2;
  assign bus.rd        = out_q.dec.rd;
  assign bus.fmt       = out_q.dec.fmt;
  assign bus.illegal   = out_q.dec.illegal;

  // next output/skid state: flush wins, then FIFO refill
  always_comb begin
    out_d      = out_q;
    out_vld_d  = out_vld_q;
    skid_d     = skid_q;
    skid_vld_d = skid_vld_q;
    if (bus.flush) begin
      out_vld_d  = 1'b0;
      skid_vld_d = 1'b0;
    end else if (out_fire || !out_vld_q) begin
      if (skid_vld_q) begin
        out_d      = skid_q;
        out_vld_d  = 1'b1;
        skid_vld_d = 1'b0;
      end else if (in_fire) begin
        out_d     = in_pl;
        out_vld_d = 1'b1;
      end else begin
        out_vld_d = 1'b0;
      end
    end else if (in_fire) begin
      skid_d     = in_pl;
      skid_vld_d = 1'b1;
    end
  end

  // state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      out_q      <= '0;
      skid_q     <= '0;
      out_vld_q  <= 1'b0;
      skid_vld_q <= 1'b0;
    end else begin
      out_q      <= out_d;
      skid_q     <= skid_d;
      out_vld_q  <= out_vld_d;
      skid_vld_q <= skid_vld_d;
    end
  end

endmodule

// File: doc/decode_stage.md
# decode_stage

Registered RISC-V instruction-decode pipeline stage with valid/ready handshaking on both sides, parametrised for RV32 or RV64. It sits between fetch and execute. It splits each 32-bit instruction into opcode, funct3, funct7, register indices and the sign-extended immediate, and classifies the instruction format. It flags illegal encodings, and a skid buffer gives full throughput under backpressure. Flush support discards in-flight instructions on redirect.

## Interface
- XLEN, 32: datapath width; 32 or 64 only. Sets the immediate and PC width and the legality of the *W opcodes.
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- flush  in  1  discard all held instructions and any instruction accepted this cycle
- in_valid  in  1  upstream instruction valid
- in_ready  out  1  stage can accept; transfer occurs when in_valid && in_ready
- in_insn  in  32  raw instruction
- in_pc  in  XLEN  instruction address
- out_valid  out  1  decoded instruction valid
- out_ready  in  1  downstream accepts; transfer occurs when out_valid && out_ready
- out_pc  out  XLEN  PC of the decoded instruction
- opcode  out  7  insn[6:0]
- funct3  out  3  insn[14:12]
- funct7  out  7  insn[31:25]
- rs1, rs2, rd  out  5 each  insn[19:15], insn[24:20], insn[11:7]
- imm  out  XLEN  sign-extended immediate
- fmt  out  3  decode_pkg::fmt_t: R, I, S, B, U, J or NONE
- illegal  out  1  unrecognised or unsupported encoding

## Operation
- Decode is combinational on in_insn and is captured into the output register or the skid register on acceptance.
- Format is selected by opcode[6:2]:
  - 01101 LUI and 00101 AUIPC: U.
  - 11011 JAL: J.
  - 11000 branches: B.
  - 11001 JALR, 00100 OP-IMM and 00000 loads: I.
  - 01000 stores: S.
  - 01100 OP: R.
  - 00011 MISC-MEM and 11100 SYSTEM: I.
  - XLEN=64 only: 00110 OP-IMM-32 is I and 01110 OP-32 is R.
- Immediates are sign-extended from insn[31] to XLEN. U-type is {insn[31:12],12'b0}, sign-extended to XLEN. R-type imm is 0.
- illegal=1 when either of the following holds. The stage then forces fmt=NONE and imm=0; there are never X outputs. Raw fields still pass through.
  - opcode[1:0] != 2'b11.
  - opcode[6:2] is not listed above, including 00110 and 01110 when XLEN=32.
- An illegal instruction still completes the handshake normally. Trapping is downstream's job.
- Skid buffer:
  - in_ready is the registered value !skid_valid.
  - If the input is accepted while out_valid && !out_ready, the payload goes to the skid register.
  - When the output is accepted, the output register loads the skid payload if skid_valid, else the input payload if accepted, else out_valid clears.
  - Order is strictly FIFO. No instruction is dropped or duplicated.

## Timing
- Latency: 1 cycle from input acceptance to out_valid, when the output register is free.
- Throughput: 1 instruction per cycle while out_ready=1.
- in_ready falls the cycle after the skid register fills, and rises the cycle after the skid register drains.
- Output payload is stable while out_valid && !out_ready.
- Reset:
  - While reset is asserted: out_valid=0, skid_valid=0, and in_ready=0.
  - In the first cycle after reset, in_ready=1.
  - All payload outputs reset to 0 and fmt resets to NONE.
- Flush:
  - In the cycle flush is sampled, out_valid and skid_valid clear on the next edge.
  - Any same-cycle input transfer is discarded.
  - in_ready=1 the following cycle.
  - A handshake that fires in the flush cycle still counts as consumed downstream.
- Simultaneous events:
  - Output accept plus input accept with the skid empty: the output register loads the new input.
  - reset takes priority over flush, which takes priority over the handshake.

## Structure
- Package decode_pkg holds:
  - fmt_t enum: FMT_NONE=0, R, I, S, B, U, J.
  - Opcode[6:2] localparams: OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD, OPC_STORE, OPC_OPIMM, OPC_OP, OPC_OPIMM32, OPC_OP32, OPC_MISCMEM, OPC_SYSTEM.
  - Packed struct decoded_t for the registered payload.
- One sub-module, decode_fields #(XLEN): purely combinational field, imm, fmt and illegal extraction. It is instantiated once on in_insn. decode_stage adds the output/skid registers and the handshake.

## Test plan
- addi x1,x2,-1 (0xFFF10093), XLEN=32, out_ready=1 -> 1 cycle later: out_valid=1, opcode=0x13, rd=1, rs1=2, imm=0xFFFFFFFF, fmt=I, illegal=0.
- lui x5,0x80000 (0x800002B7) -> imm=0x80000000 at XLEN=32 and 0xFFFFFFFF80000000 at XLEN=64, fmt=U.
- jal x0,-4 (0xFFDFF06F) -> imm=0xFFFFFFFC, fmt=J. beq x0,x0,+8 (0x00000463) -> imm=8, fmt=B.
- Illegal encodings:
  - 0x00000000 -> illegal=1, fmt=NONE, imm=0.
  - addiw 0x0000001B -> illegal=1 at XLEN=32; illegal=0, fmt=I at XLEN=64.
- Backpressure: hold out_ready=0 and stream 3 instructions A, B, C -> A sits in the output register, B goes to skid, in_ready=0 the next cycle, C is held upstream. Release out_ready -> A, B, C emerge in order on consecutive cycles with no loss.
- Flush with both registers full, and separately reset asserted mid-stream -> next cycle out_valid=0. in_ready=1 after flush, and in the first cycle after reset deasserts. The next accepted instruction decodes normally.
